// File: rtl/bottle_pkg.sv
// ---------------------------------------------------------------------------
// bottle_pkg
// Shared definitions for the jump path: the default command width, the jump
// charger state type and the distance defaults that the game fsm also uses.
// ---------------------------------------------------------------------------
package bottle_pkg;

  // Default width of jump_dist and of the charge count
  localparam int DEF_DIST_W     = 8;
  // Default number of frame ticks per +1 of charge
  localparam int DEF_CHARGE_DIV = 4;
  // Distance fired for a tap shorter than one charge period
  localparam int DEF_MIN_DIST   = 1;
  // Saturation value of the charge count
  localparam int DEF_MAX_DIST   = 30;

  // Jump charger states, fixed 2-bit encoding
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHARGE = 2'd1,
    FIRE   = 2'd2,
    LOCK   = 2'd3
  } jump_state_t;

endpackage : bottle_pkg

// File: rtl/charge_prescaler.sv
// ---------------------------------------------------------------------------
// charge_prescaler
// Tick-enabled modulo-DIV counter. inc is high in the cycle where an enabled
// count would wrap from DIV-1 back to 0, i.e. once every DIV enabled ticks.
//
// Ports
//   clk    in   system clock
//   clr_n  in   asynchronous active-low reset
//   clear  in   synchronous clear, wins over en
//   en     in   count enable (already qualified with the frame tick)
//   inc    out  wrap pulse, combinational from en and the count
// ---------------------------------------------------------------------------
module charge_prescaler
  import bottle_pkg::*;
#(
  parameter int DIV = DEF_CHARGE_DIV
) (
  input  logic clk,
  input  logic clr_n,
  input  logic clear,
  input  logic en,
  output logic inc
);

  // A DIV of 1 still needs a 1-bit counter; it simply never leaves 0.
  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] cnt_r;
  logic          at_last_s;

  assign at_last_s = (cnt_r == LAST);
  assign inc       = en && at_last_s;

  // Prescale counter: clears synchronously, otherwise counts enabled ticks mod DIV
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt_r <= '0;
    end else if (clear) begin
      cnt_r <= '0;
    end else if (en) begin
      cnt_r <= at_last_s ? '0 : (cnt_r + ONE);
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule : charge_prescaler

// File: rtl/jump_charger.sv
// ---------------------------------------------------------------------------
// jump_charger
// Turns how long the debounced jump button is held into a one-frame jump_dist
// command for the game fsm. All state moves only on frame_tick cycles, so the
// charge rate is tied to the render frame rate rather than to clk.
//
// Ports
//   clk          in   system clock
//   clr_n        in   asynchronous active-low reset
//   frame_tick   in   1-cycle strobe per render frame
//   jump_btn     in   debounced button level, 1 = pressed
//   busy         in   fsm is animating a jump; new presses are ignored
//   restart      in   synchronous clear, overrides every other input
//   jump_dist    out  fired distance, nonzero for one frame, else 0
//   charging     out  1 while charging (decoded from state)
//   charge_lvl   out  live charge count for the display
//   end_of_jump  out  1-cycle pulse on the tick that returns jump_dist to 0
//
// Build option
//   JUMP_AUTOFIRE_EN  when defined, a charge sitting at MAX_DIST fires on the
//                     next tick even if the button is still held; LOCK then
//                     waits for the release before re-arming.
// ---------------------------------------------------------------------------
module jump_charger
  import bottle_pkg::*;
#(
  parameter int DIST_W     = DEF_DIST_W,
  parameter int CHARGE_DIV = DEF_CHARGE_DIV,
  parameter int MIN_DIST   = DEF_MIN_DIST,
  parameter int MAX_DIST   = DEF_MAX_DIST
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              frame_tick,
  input  logic              jump_btn,
  input  logic              busy,
  input  logic              restart,
  output logic [DIST_W-1:0] jump_dist,
  output logic              charging,
  output logic [DIST_W-1:0] charge_lvl,
  output logic              end_of_jump
);

  localparam logic [DIST_W-1:0] MIN_V = DIST_W'(MIN_DIST);
  localparam logic [DIST_W-1:0] MAX_V = DIST_W'(MAX_DIST);
  localparam logic [DIST_W-1:0] ONE_V = DIST_W'(1);

  jump_state_t       state_r;
  jump_state_t       state_nxt_s;
  logic [DIST_W-1:0] charge_lvl_r;
  logic [DIST_W-1:0] charge_lvl_nxt_s;
  logic [DIST_W-1:0] jump_dist_r;
  logic [DIST_W-1:0] jump_dist_nxt_s;
  logic              end_of_jump_r;
  logic              end_of_jump_nxt_s;

  logic              presc_clear_s;
  logic              presc_en_s;
  logic              presc_inc_s;

  // The prescaler only runs while charging with the button held; on every
  // other tick it is parked at 0 so a fresh charge always starts clean.
  assign presc_en_s    = frame_tick && (state_r == CHARGE) && jump_btn;
  assign presc_clear_s = restart || (frame_tick && (state_r != CHARGE));

  charge_prescaler #(
    .DIV (CHARGE_DIV)
  ) u_prescaler (
    .clk   (clk),
    .clr_n (clr_n),
    .clear (presc_clear_s),
    .en    (presc_en_s),
    .inc   (presc_inc_s)
  );

  // Next-state and next-output logic; everything holds on non-tick cycles
  always_comb begin
    state_nxt_s       = state_r;
    charge_lvl_nxt_s  = charge_lvl_r;
    jump_dist_nxt_s   = jump_dist_r;
    end_of_jump_nxt_s = 1'b0;

    if (frame_tick) begin
      case (state_r)
        IDLE: begin
          // A press while busy is dropped, not queued.
          if (jump_btn && !busy) begin
            state_nxt_s      = CHARGE;
            charge_lvl_nxt_s = '0;
          end else begin
            state_nxt_s = IDLE;
          end
        end

        CHARGE: begin
          if (!jump_btn) begin
            state_nxt_s     = FIRE;
            jump_dist_nxt_s = (charge_lvl_r == '0) ? MIN_V : charge_lvl_r;
          end
`ifdef JUMP_AUTOFIRE_EN
          else if (charge_lvl_r == MAX_V) begin
            state_nxt_s     = FIRE;
            jump_dist_nxt_s = MAX_V;
          end
`endif
          else if (presc_inc_s) begin
            // Saturate rather than wrap once the ceiling is reached.
            charge_lvl_nxt_s = (charge_lvl_r >= MAX_V) ? MAX_V : (charge_lvl_r + ONE_V);
          end else begin
            charge_lvl_nxt_s = charge_lvl_r;
          end
        end

        FIRE: begin
          state_nxt_s       = LOCK;
          jump_dist_nxt_s   = '0;
          charge_lvl_nxt_s  = '0;
          end_of_jump_nxt_s = 1'b1;
        end

        LOCK: begin
          // Require a seen release so a long hold cannot re-trigger.
          if (!jump_btn && !busy) begin
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = LOCK;
          end
        end

        default: begin
          state_nxt_s      = IDLE;
          charge_lvl_nxt_s = '0;
          jump_dist_nxt_s  = '0;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // State and output registers with async reset and restart as sync clear
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_r       <= IDLE;
      charge_lvl_r  <= '0;
      jump_dist_r   <= '0;
      end_of_jump_r <= 1'b0;
    end else if (restart) begin
      state_r       <= IDLE;
      charge_lvl_r  <= '0;
      jump_dist_r   <= '0;
      end_of_jump_r <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      charge_lvl_r  <= charge_lvl_nxt_s;
      jump_dist_r   <= jump_dist_nxt_s;
      end_of_jump_r <= end_of_jump_nxt_s;
    end
  end

  assign jump_dist   = jump_dist_r;
  assign charge_lvl  = charge_lvl_r;
  assign end_of_jump = end_of_jump_r;
  assign charging    = (state_r == CHARGE);

endmodule : jump_charger

// File: tb/tb_jump_charger.sv
// ---------------------------------------------------------------------------
// tb_jump_charger
// Directed scenarios plus a random phase, each checked cycle by cycle against
// a behavioural model. The model tracks how many held ticks have elapsed in a
// charge and derives the charge as min(held/DIV, MAX) instead of stepping a
// prescaler.
// ---------------------------------------------------------------------------
module tb_jump_charger;

  localparam int W   = 8;
  localparam int DIV = 4;
  localparam int MIN = 1;
  localparam int MAX = 30;

  logic         clk;
  logic         clr_n;
  logic         frame_tick;
  logic         jump_btn;
  logic         busy;
  logic         restart;
  logic [W-1:0] jump_dist;
  logic         charging;
  logic [W-1:0] charge_lvl;
  logic         end_of_jump;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit m_in_charge;  // arming accepted, button being held
  bit m_lock;       // waiting for release after a jump
  int m_held;       // held ticks counted since the charge began
  int m_dist;       // distance currently being shown, 0 when none
  bit m_eoj;

  jump_charger #(
    .DIST_W     (W),
    .CHARGE_DIV (DIV),
    .MIN_DIST   (MIN),
    .MAX_DIST   (MAX)
  ) dut (
    .clk         (clk),
    .clr_n       (clr_n),
    .frame_tick  (frame_tick),
    .jump_btn    (jump_btn),
    .busy        (busy),
    .restart     (restart),
    .jump_dist   (jump_dist),
    .charging    (charging),
    .charge_lvl  (charge_lvl),
    .end_of_jump (end_of_jump)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int m_charge();
    int c;
    c = m_held / DIV;
    return (c > MAX) ? MAX : c;
  endfunction

  task automatic m_reset();
    m_in_charge = 1'b0;
    m_lock      = 1'b0;
    m_held      = 0;
    m_dist      = 0;
    m_eoj       = 1'b0;
  endtask

  // One clock edge of the model
  task automatic m_edge(input bit b, input bit bz, input bit t, input bit r);
    int cv;
    m_eoj = 1'b0;
    if (r) begin
      m_reset();
    end else if (t) begin
      cv = m_charge();
      if (m_dist != 0) begin
        m_dist = 0;
        m_eoj  = 1'b1;
        m_lock = 1'b1;
        m_held = 0;
      end else if (m_lock) begin
        if (!b && !bz) m_lock = 1'b0;
      end else if (m_in_charge) begin
        if (!b) begin
          m_dist      = (cv == 0) ? MIN : cv;
          m_in_charge = 1'b0;
        end
`ifdef JUMP_AUTOFIRE_EN
        else if (cv == MAX) begin
          m_dist      = MAX;
          m_in_charge = 1'b0;
        end
`endif
        else begin
          m_held++;
        end
      end else if (b && !bz) begin
        m_in_charge = 1'b1;
        m_held      = 0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    int exp_lvl;
    exp_lvl = (m_in_charge || (m_dist != 0)) ? m_charge() : 0;
    chk("jump_dist",   32'(jump_dist),   32'(m_dist));
    chk("charge_lvl",  32'(charge_lvl),  32'(exp_lvl));
    chk("charging",    32'(charging),    32'(m_in_charge));
    chk("end_of_jump", 32'(end_of_jump), 32'(m_eoj));
  endtask

  // Drive one clk cycle, step the model on the edge, check just after it
  task automatic cyc(input bit b, input bit bz, input bit t, input bit r);
    @(negedge clk);
    jump_btn   = b;
    busy       = bz;
    frame_tick = t;
    restart    = r;
    @(posedge clk);
    m_edge(b, bz, t, r);
    #1;
    chk_all();
  endtask

  // n frames with a random 0..2 idle cycles before each tick
  task automatic frames(input int n, input bit b, input bit bz);
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) cyc(b, bz, 1'b0, 1'b0);
      cyc(b, bz, 1'b1, 1'b0);
    end
  endtask

  initial begin
    bit rb;
    bit rbz;
    clr_n      = 1'b0;
    frame_tick = 1'b0;
    jump_btn   = 1'b0;
    busy       = 1'b0;
    restart    = 1'b0;
    m_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_all();
    @(negedge clk);
    clr_n = 1'b1;
    frames(2, 1'b0, 1'b0);

    // Hold: one tick to arm, 12 charging ticks, then release
    frames(13, 1'b1, 1'b0);
    chk("hold12_lvl", 32'(charge_lvl), 32'd3);
    frames(1, 1'b0, 1'b0);
    chk("hold12_dist", 32'(jump_dist), 32'd3);
    frames(3, 1'b0, 1'b0);

    // Tap: arm on one tick, released on the next
    frames(1, 1'b1, 1'b0);
    frames(1, 1'b0, 1'b0);
    chk("tap_dist", 32'(jump_dist), 32'(MIN));
    frames(3, 1'b0, 1'b0);

    // Long hold saturates at MAX, release fires MAX
    frames(200, 1'b1, 1'b0);
    frames(3, 1'b0, 1'b0);
    frames(2, 1'b0, 1'b0);

    // Press while busy is ignored; dropping busy with btn held arms
    frames(3, 1'b1, 1'b1);
    chk("busy_charging", 32'(charging), 32'd0);
    frames(2, 1'b1, 1'b0);
    chk("busy_drop_charging", 32'(charging), 32'd1);
    frames(2, 1'b0, 1'b0);
    frames(3, 1'b0, 1'b0);

    // Restart mid-charge at level 5, then no fire on release
    frames(21, 1'b1, 1'b0);
    chk("pre_restart_lvl", 32'(charge_lvl), 32'd5);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    frames(3, 1'b0, 1'b0);

    // Async reset while firing, between ticks
    frames(9, 1'b1, 1'b0);
    frames(1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    frame_tick = 1'b0;
    clr_n      = 1'b0;
    #1;
    m_reset();
    chk("async_dist", 32'(jump_dist), 32'd0);
    chk_all();
    @(negedge clk);
    clr_n = 1'b1;
    frames(3, 1'b1, 1'b0);
    chk("post_reset_charging", 32'(charging), 32'd1);
    frames(2, 1'b0, 1'b0);
    frames(3, 1'b0, 1'b0);

    // Random phase: sticky button/busy, sparse ticks, rare restart
    rb  = 1'b0;
    rbz = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) rb = ~rb;
      if ($urandom_range(0, 15) == 0) rbz = ~rbz;
      cyc(rb, rbz, ($urandom_range(0, 2) != 0), ($urandom_range(0, 150) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_jump_charger
